// File: rtl/fft_8_bitrev_reorder.sv
// Reorders 8-point FFT output from bit-reversed to natural bin order.
// Uses ping-pong banks so one frame is filled while the previous one drains.
module fft_8_bitrev_reorder #(
  parameter int DATA_W = 37
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [2:0]        bin_out,
  output logic              sof_out,
  output logic              eof_out
);

  typedef enum logic {IDLE, READ} state_t;

  state_t            state, state_next;
  logic [2:0]        wr_cnt, rd_cnt;
  logic              wr_bank, rd_bank;
  logic              rd_pend;
  logic              frame_done;
  logic              rd_start;
  logic [DATA_W-1:0] mem [2][8];

  assign frame_done = valid_in && (wr_cnt == 3'd7);

  always_comb begin
    state_next = state;
    rd_start   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_done || rd_pend) begin
          rd_start   = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        // The last read of a frame may coincide with the next frame completing.
        if (rd_cnt == 3'd7) begin
          if (frame_done || rd_pend) rd_start = 1'b1;
          else                       state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt  <= 3'd0;
      wr_bank <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      if (valid_in) begin
        wr_cnt <= wr_cnt + 3'd1;
        if (wr_cnt == 3'd7) wr_bank <= ~wr_bank;
      end
      rd_pend <= (rd_pend || frame_done) && !rd_start;
    end
  end

  // Bank storage is left unreset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (valid_in) mem[wr_bank][{wr_cnt[0], wr_cnt[1], wr_cnt[2]}] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt    <= 3'd0;
      rd_bank   <= 1'b0;
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      eof_out   <= 1'b0;
      bin_out   <= 3'd0;
      data_out  <= '0;
    end else begin
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      eof_out   <= 1'b0;
      if (state == READ) begin
        data_out  <= mem[rd_bank][rd_cnt];
        bin_out   <= rd_cnt;
        valid_out <= 1'b1;
        sof_out   <= (rd_cnt == 3'd0);
        eof_out   <= (rd_cnt == 3'd7);
        rd_cnt    <= rd_cnt + 3'd1;
      end
      // A pending request refers to the bank already swapped away from writing.
      if (rd_start) begin
        rd_cnt  <= 3'd0;
        rd_bank <= frame_done ? wr_bank : ~wr_bank;
      end
    end
  end

endmodule

// File: doc/fft_8_bitrev_reorder.md
FFT_8_BITREV_REORDER -- requirements
Module: fft_8_bitrev_reorder

Interface
REQ-001 SHALL have parameter DATA_W, default 37, the width of one opaque FFT output word passed through unmodified.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port valid_in  input  1  data_in carries a valid FFT output word this cycle.
REQ-005 SHALL have port data_in  input  DATA_W  FFT output word, arriving in bit-reversed bin order (bins 0,4,2,6,1,5,3,7).
REQ-006 SHALL have port valid_out  output  1  data_out/bin_out carry a valid word this cycle.
REQ-007 SHALL have port data_out  output  DATA_W  reordered word, natural bin order 0..7.
REQ-008 SHALL have port bin_out  output  3  bin index of data_out.
REQ-009 SHALL have port sof_out  output  1  high with bin 0 of each output frame.
REQ-010 SHALL have port eof_out  output  1  high with bin 7 of each output frame.

Function
REQ-011 SHALL hold two 8-entry x DATA_W banks (ping-pong): one written while the other is read.
REQ-012 SHALL keep a 3-bit write counter wr_cnt; on each cycle with valid_in=1, store data_in at address bitrev3(wr_cnt) of the write bank, then increment wr_cnt modulo 8.
REQ-013 SHALL hold wr_cnt and write nothing on cycles with valid_in=0; gaps in input are allowed anywhere within a frame.
REQ-014 SHALL, on the edge that stores the 8th word (wr_cnt 7->0), swap banks and request a read of the just-filled bank.
REQ-015 SHALL implement read FSM states IDLE and READ: IDLE->READ on read request; READ reads address rd_cnt 0..7, one per cycle; READ->IDLE after rd_cnt=7 unless a new read request is pending on that edge, in which case READ restarts at rd_cnt=0 with no bubble.
REQ-016 SHALL register outputs: bin k of a frame appears on data_out with valid_out=1 exactly k+1 cycles after the edge storing the frame's 8th word (latency 1 cycle to bin 0, 8 cycles to bin 7).
REQ-017 SHALL drive bin_out=rd_cnt, sof_out=1 only for bin 0, eof_out=1 only for bin 7, all qualified by valid_out.
REQ-018 SHALL emit each output frame as 8 consecutive valid_out cycles, never stalled.
REQ-019 SHALL never overwrite the bank under read: a new frame needs >=8 input cycles, so its completion coincides at earliest with the last read of the previous frame (back-to-back case of REQ-015).
REQ-020 SHALL, with continuous valid_in, produce continuous valid_out with no gaps between frames.
REQ-021 SHALL hold data_out, bin_out at their last values when valid_out=0; valid_out, sof_out, eof_out SHALL be 0.

Reset
REQ-022 SHALL, when rst_n=0 at a rising edge, clear wr_cnt, rd_cnt to 0, select bank 0 for write, set FSM to IDLE, clear any pending read request, drive valid_out, sof_out, eof_out, bin_out, data_out to 0.
REQ-023 SHALL discard a partially written input frame and abort an in-progress output frame on reset; bank contents need not be cleared.
REQ-024 SHALL accept valid_in on the first edge with rst_n=1 as bin position 0 of a new frame.

Verification
REQ-025 Single frame: after reset, valid_in=1 for 8 cycles with data_in = 100,104,102,106,101,105,103,107 -> one cycle after the 8th, 8 cycles of valid_out with data_out 100..107, bin_out 0..7, sof_out on first, eof_out on last.
REQ-026 Back-to-back: 3 frames continuous valid_in (second frame values 200+bin, third 300+bin) -> 24 consecutive valid_out cycles in natural order, sof_out every 8th, no gap.
REQ-027 Gapped input: same frame as REQ-025 with valid_in low 1 cycle between each word -> identical output sequence, starting 1 cycle after 8th valid word.
REQ-028 Reset mid-frame: 5 words written, rst_n low 1 cycle, then full frame 100..107 (bit-reversed) -> output is only 100..107 in order; no output from the partial frame.
REQ-029 Reset mid-read: assert rst_n=0 during bin 3 of an output frame -> valid_out=0 on the next cycle and no remaining bins emitted.
REQ-030 Idle: valid_in=0 for 20 cycles after reset -> valid_out, sof_out, eof_out stay 0, data_out stays 0.
